// File: rtl/hsdaoh_pkg.sv
// Shared definitions for the hsdaoh stream arbiter and the host-side decoder.
// Holds the framing marks, field positions and widths of header and trailer words,
// the arbiter state encoding, and helpers that build header and trailer words.
package hsdaoh_pkg;

  localparam logic [3:0]  HDR_MARK    = 4'hA;
  localparam logic [3:0]  TRL_MARK    = 4'h5;

  // Field layout, shared with the host decoder
  localparam int unsigned MARK_LSB    = 12;
  localparam int unsigned HDR_ID_LSB  = 8;
  localparam int unsigned HDR_SEQ_LSB = 0;
  localparam int unsigned ID_W        = 4;
  localparam int unsigned SEQ_W       = 8;
  localparam int unsigned CNT_W       = 12;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StHeader  = 2'd1,
    StBurst   = 2'd2,
    StTrailer = 2'd3
  } arb_state_e;

  function automatic logic [15:0] make_header(input logic [ID_W-1:0] id,
                                              input logic [SEQ_W-1:0] seq);
    return (16'(HDR_MARK) << MARK_LSB) | (16'(id) << HDR_ID_LSB) | (16'(seq) << HDR_SEQ_LSB);
  endfunction

  function automatic logic [15:0] make_trailer(input logic [CNT_W-1:0] cnt);
    return (16'(TRL_MARK) << MARK_LSB) | 16'(cnt);
  endfunction

endpackage

// File: rtl/hsdaoh_stream_arbiter_if.sv
// Bundle of source streams and FIFO write port around hsdaoh_stream_arbiter.
//  master : arbiter side (consumes src_*, fifo_full; drives ready, FIFO write, status)
//  slave  : environment side (sources, FIFO, status consumer)
interface hsdaoh_stream_arbiter_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DW      = 16
);
  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC*DW-1:0] src_data;
  logic [NUM_SRC-1:0]    src_ready;
  logic [NUM_SRC-1:0]    src_enable;
  logic                  fifo_full;
  logic                  fifo_wen;
  logic [DW-1:0]         fifo_wdata;
  logic [3:0]            grant_id;
  logic                  busy;
  logic [15:0]           stall_cycles;

  modport master (
    input  src_valid, src_data, src_enable, fifo_full,
    output src_ready, fifo_wen, fifo_wdata, grant_id, busy, stall_cycles
  );

  modport slave (
    output src_valid, src_data, src_enable, fifo_full,
    input  src_ready, fifo_wen, fifo_wdata, grant_id, busy, stall_cycles
  );
endinterface

// File: rtl/hsdaoh_rr_pick.sv
// Combinational round-robin picker.
//  req   : request vector
//  last  : index granted last time; search starts at last+1 and wraps
//  found : some request is set
//  idx   : index of the winning request (0 when none)
module hsdaoh_rr_pick
  import hsdaoh_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    int unsigned c;
    c     = 0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      c = (32'(last) + k) % NUM_SRC;
      if (!found && (|(req & (NUM_SRC'(1) << c)))) begin
        found = 1'b1;
        idx   = ID_W'(c);
      end
    end
  end

endmodule

// File: rtl/hsdaoh_stream_arbiter.sv
// Round-robin scheduler sharing one 16-bit FIFO write port between NUM_SRC streams.
// Each grant emits a framed burst: header {A, id, seq}, up to BURST_LEN payload words,
// trailer {5, count}. fifo_full stalls everything; no word is dropped or duplicated.
//  clk_data, rst : data clock, asynchronous active-high reset
//  bus (master)  : src_valid/src_data/src_ready/src_enable, fifo_full/fifo_wen/fifo_wdata,
//                  grant_id, busy, stall_cycles
module hsdaoh_stream_arbiter
  import hsdaoh_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned BURST_LEN = 256,
  parameter int unsigned DW        = 16
) (
  input  logic                     clk_data,
  input  logic                     rst,
  hsdaoh_stream_arbiter_if.master  bus
);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    grant_q, ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SEQ_W-1:0]   seq_q [NUM_SRC];
  logic [15:0]        stall_q;

  logic [NUM_SRC-1:0] gsel;
  logic               cur_valid;
  logic [DW-1:0]      cur_data;
  logic [SEQ_W-1:0]   cur_seq;
  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  logic               full, hdr_wr, xfer, last_word, stall_evt;

  hsdaoh_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req   (bus.src_valid & bus.src_enable),
    .last  (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign full      = bus.fifo_full;
  assign gsel      = NUM_SRC'(1) << grant_q;
  assign cur_valid = |(bus.src_valid & gsel);

  always_comb begin
    cur_data = '0;
    cur_seq  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (gsel[i]) begin
        cur_data = bus.src_data[i*DW +: DW];
        cur_seq  = seq_q[i];
      end
    end
  end

  assign hdr_wr    = (state_q == StHeader) && !full;
  assign xfer      = (state_q == StBurst) && cur_valid && !full;
  assign last_word = (cnt_q + 1'b1) == CNT_W'(BURST_LEN);
  // A source dropping valid during a stall is not an idle gap, but the cycle still counts
  // as stalled only if a payload word was actually waiting.
  assign stall_evt = full && ((state_q == StHeader) || (state_q == StTrailer) ||
                              ((state_q == StBurst) && cur_valid));

  // State register
  always_ff @(posedge clk_data or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (pick_found) state_d = StHeader;
      StHeader:  if (!full) state_d = StBurst;
      StBurst:   if (!full && (!cur_valid || last_word)) state_d = StTrailer;
      StTrailer: if (!full) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs; IDLE drives all zeros so an asserted reset clears them at once
  always_comb begin
    bus.src_ready  = '0;
    bus.fifo_wen   = 1'b0;
    bus.fifo_wdata = '0;
    unique case (state_q)
      StIdle: ;
      StHeader: begin
        bus.fifo_wdata = DW'(make_header(grant_q, cur_seq));
        bus.fifo_wen   = !full;
      end
      StBurst: begin
        bus.src_ready  = full ? '0 : gsel;
        bus.fifo_wdata = cur_data;
        bus.fifo_wen   = cur_valid && !full;
      end
      StTrailer: begin
        bus.fifo_wdata = DW'(make_trailer(cnt_q));
        bus.fifo_wen   = !full;
      end
      default: ;
    endcase
  end

  assign bus.grant_id     = grant_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.stall_cycles = stall_q;

  // Datapath registers
  always_ff @(posedge clk_data or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      ptr_q   <= ID_W'(NUM_SRC - 1);
      cnt_q   <= '0;
      stall_q <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) seq_q[i] <= '0;
    end else begin
      if ((state_q == StIdle) && pick_found) begin
        grant_q <= pick_idx;
        ptr_q   <= pick_idx;
      end
      if (hdr_wr) begin
        cnt_q <= '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if (gsel[i]) seq_q[i] <= seq_q[i] + 1'b1;
        end
      end
      if (xfer) cnt_q <= cnt_q + 1'b1;
      if (stall_evt && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_hsdaoh_stream_arbiter.sv
module tb_hsdaoh_stream_arbiter;

  logic clk_data = 1'b0;
  logic rst      = 1'b1;
  always #5 clk_data = ~clk_data;

  hsdaoh_stream_arbiter_if #(.NUM_SRC(4), .DW(16)) bus ();

  hsdaoh_stream_arbiter #(
    .NUM_SRC   (4),
    .BURST_LEN (4),
    .DW        (16)
  ) dut (
    .clk_data (clk_data),
    .rst      (rst),
    .bus      (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] wq [$];
  logic [15:0] dat [4];
  int          lim [4];
  logic [3:0]  en_v;
  int          full_viol   = 0;
  int          onehot_viol = 0;
  int          ready_seen  = 0;

  logic [15:0] exp1 [12] = '{16'hA000, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h5004,
                             16'hA001, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h5004};
  logic [15:0] exp3 [12] = '{16'hA200, 16'h2000, 16'h2001, 16'h5002, 16'hA300, 16'h3000,
                             16'h3001, 16'h3002, 16'h3003, 16'h5004, 16'hA201, 16'h2002};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] wget(input int idx);
    if (idx < wq.size()) return wq[idx];
    return 'x;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) bus.src_valid[i] = en_v[i] && (lim[i] != 0);
    bus.src_data = {dat[3], dat[2], dat[1], dat[0]};
  endtask

  // One clock: observe at negedge, advance sources after the posedge
  task automatic cycle();
    logic [3:0] hs;
    @(negedge clk_data);
    if (bus.fifo_wen) wq.push_back(bus.fifo_wdata);
    if (bus.fifo_full && (bus.fifo_wen || bus.src_ready != 4'b0)) full_viol++;
    if (bus.src_ready != 4'b0) begin
      ready_seen++;
      if (bus.src_ready != (4'b1 << bus.grant_id)) onehot_viol++;
    end
    hs = bus.src_valid & bus.src_ready;
    @(posedge clk_data);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        dat[i] = dat[i] + 16'd1;
        if (lim[i] > 0) lim[i] = lim[i] - 1;
      end
    end
    drive();
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int k = 0;
    while (wq.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk(tag, 32'(wq.size() >= n), 32'd1);
  endtask

  task automatic do_reset(input logic [3:0] en, input logic [3:0] vld);
    rst           = 1'b1;
    bus.fifo_full = 1'b0;
    en_v          = 4'b0;
    drive();
    cycle();
    cycle();
    wq.delete();
    for (int i = 0; i < 4; i++) begin
      dat[i] = 16'(i) << 12;
      lim[i] = -1;
    end
    bus.src_enable = en;
    en_v           = vld;
    drive();
    rst = 1'b0;
  endtask

  initial begin
    bus.src_enable = 4'b0;
    bus.fifo_full  = 1'b0;
    en_v           = 4'b0;
    for (int i = 0; i < 4; i++) begin
      dat[i] = 16'(i) << 12;
      lim[i] = -1;
    end
    drive();
    cycle();
    cycle();

    // Reset state
    chk("rst_wen",   32'(bus.fifo_wen), 32'd0);
    chk("rst_wdata", 32'(bus.fifo_wdata), 32'd0);
    chk("rst_ready", 32'(bus.src_ready), 32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_stall", 32'(bus.stall_cycles), 32'd0);

    // 1: single source, two full bursts
    do_reset(4'b0001, 4'b0001);
    wait_writes("t1_count", 12, 40);
    for (int i = 0; i < 12; i++) chk($sformatf("t1_w%0d", i), 32'(wget(i)), 32'(exp1[i]));

    // 2: all sources, round-robin header order
    do_reset(4'b1111, 4'b1111);
    wait_writes("t2_count", 30, 80);
    chk("t2_h0", 32'(wget(0)),  32'hA000);
    chk("t2_h1", 32'(wget(6)),  32'hA100);
    chk("t2_h2", 32'(wget(12)), 32'hA200);
    chk("t2_h3", 32'(wget(18)), 32'hA300);
    chk("t2_h4", 32'(wget(24)), 32'hA001);
    chk("t2_p1", 32'(wget(7)),  32'h1000);
    chk("t2_t3", 32'(wget(23)), 32'h5004);

    // 3: idle gap ends a short burst
    do_reset(4'b1100, 4'b1100);
    lim[2] = 2;
    lim[3] = 4;
    drive();
    wait_writes("t3_count_a", 10, 60);
    lim[2] = -1;
    drive();
    wait_writes("t3_count_b", 12, 40);
    for (int i = 0; i < 12; i++) chk($sformatf("t3_w%0d", i), 32'(wget(i)), 32'(exp3[i]));

    // 4: FIFO full for 10 cycles mid-burst
    do_reset(4'b0001, 4'b0001);
    wait_writes("t4_count_a", 2, 20);
    bus.fifo_full = 1'b1;
    #1;
    chk("t4_wen_full",   32'(bus.fifo_wen), 32'd0);
    chk("t4_ready_full", 32'(bus.src_ready), 32'd0);
    repeat (10) cycle();
    bus.fifo_full = 1'b0;
    chk("t4_stall", 32'(bus.stall_cycles), 32'd10);
    wait_writes("t4_count_b", 12, 40);
    for (int i = 0; i < 12; i++) chk($sformatf("t4_w%0d", i), 32'(wget(i)), 32'(exp1[i]));

    // 5: sequence number wrap on src1
    do_reset(4'b0010, 4'b0010);
    wait_writes("t5_count", 1542, 2500);
    chk("t5_h255",   32'(wget(1530)), 32'hA1FF);
    chk("t5_p255",   32'(wget(1531)), 32'h13FC);
    chk("t5_h256",   32'(wget(1536)), 32'hA100);
    chk("t5_p256",   32'(wget(1537)), 32'h1400);
    chk("t5_trl",    32'(wget(1541)), 32'h5004);

    // 6: reset in the middle of a burst
    do_reset(4'b0110, 4'b0110);
    wait_writes("t6_count_a", 3, 20);
    chk("t6_pre_grant", 32'(bus.grant_id), 32'd1);
    bus.fifo_full = 1'b1;
    repeat (3) cycle();
    bus.fifo_full = 1'b0;
    chk("t6_pre_stall", 32'(bus.stall_cycles), 32'd3);
    rst = 1'b1;
    #1;
    chk("t6_wen",   32'(bus.fifo_wen), 32'd0);
    chk("t6_wdata", 32'(bus.fifo_wdata), 32'd0);
    chk("t6_ready", 32'(bus.src_ready), 32'd0);
    chk("t6_grant", 32'(bus.grant_id), 32'd0);
    chk("t6_busy",  32'(bus.busy), 32'd0);
    chk("t6_stall", 32'(bus.stall_cycles), 32'd0);
    do_reset(4'b1111, 4'b1111);
    wait_writes("t6_count_b", 1, 20);
    chk("t6_first", 32'(wget(0)), 32'hA000);

    // Invariants gathered over the whole run
    chk("inv_full_gate", 32'(full_viol), 32'd0);
    chk("inv_onehot",    32'(onehot_viol), 32'd0);
    chk("inv_ready_seen", 32'(ready_seen > 0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
